ppu_mode_sequencer: RTL and testbench

- Parametrised, deterministic scanline/frame timing engine for the PPU.
- Generates LY, dot position and STAT mode. Sequences the OAM-search and pixel-fetcher FSMs through start/done handshakes.
- Produces edge-accurate STAT (with STAT blocking) and VBLANK interrupt pulses.
- Line length is fixed by parameter regardless of mode-3 duration. Timing constants are generics so the same block serves DMG and test/scaled configurations.

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/ppu_stat_irq.sv | 42 ++++
 rtl/ppu_mode_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ppu_mode_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and DMG timing defaults for the scanline/frame sequencer.
// STAT mode encoding matches STAT[1:0].
package ppu_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } ppu_mode_t;

  localparam int DMG_DOTS_PER_LINE = 456;
  localparam int DMG_VISIBLE_LINES = 144;
  localparam int DMG_TOTAL_LINES   = 154;
  localparam int DMG_MODE2_DOTS    = 80;
  localparam int DMG_MODE3_MIN     = 172;
  localparam int DMG_MODE3_MAX     = 289;

  // sel is STAT[6:3] = {lyc, mode2, mode1, mode0}
  function automatic logic stat_line_f(input logic [3:0] sel, input ppu_mode_t mode,
                                       input logic lyc_eq);
    return (lyc_eq & sel[3]) |
           ((mode == MODE_2) & sel[2]) |
           ((mode == MODE_1) & sel[1]) |
           ((mode == MODE_0) & sel[0]);
  endfunction

endpackage

// File: rtl/ppu_stat_irq.sv
// STAT interrupt source combiner with registered rising-edge detect.
// Holding the line high across a source change produces no new request.
module ppu_stat_irq
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] stat_sel,
  input  ppu_mode_t  mode,
  input  logic       lyc_eq,
  output logic       stat_irq
);

  logic stat_line_s;
  logic stat_line_r;
  logic stat_irq_r;

  // Combine selected sources; a stopped display forces the line low
  always_comb begin
    stat_line_s = 1'b0;
    if (en) begin
      stat_line_s = stat_line_f(stat_sel, mode, lyc_eq);
    end else begin
      stat_line_s = 1'b0;
    end
  end

  // Previous line level and one-cycle request on a 0->1 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_line_r <= 1'b0;
      stat_irq_r  <= 1'b0;
    end else begin
      stat_line_r <= stat_line_s;
      stat_irq_r  <= stat_line_s & ~stat_line_r;
    end
  end

  assign stat_irq = stat_irq_r;

endmodule

// File: rtl/ppu_mode_sequencer.sv
// Scanline/frame timing engine: dot/LY counters, STAT mode FSM, m2/m3 handshakes
// and VBLANK/STAT interrupt pulses. All outputs come straight from registers.
module ppu_mode_sequencer
  import ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE = DMG_DOTS_PER_LINE,
  parameter int VISIBLE_LINES = DMG_VISIBLE_LINES,
  parameter int TOTAL_LINES   = DMG_TOTAL_LINES,
  parameter int MODE2_DOTS    = DMG_MODE2_DOTS,
  parameter int MODE3_MIN     = DMG_MODE3_MIN,
  parameter int MODE3_MAX     = DMG_MODE3_MAX,
  parameter int LY_W          = 8,
  parameter int DOT_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lcd_en,
  input  logic [3:0]       stat_sel,
  input  logic [LY_W-1:0]  lyc,
  input  logic             m3_done,
  output logic [1:0]       mode,
  output logic [LY_W-1:0]  ly,
  output logic [DOT_W-1:0] dot,
  output logic             m2_start,
  output logic             m3_start,
  output logic             lyc_eq,
  output logic             stat_irq,
  output logic             vblank_irq,
  output logic             frame_done,
  output logic             m3_overrun
);

  localparam logic [DOT_W-1:0] DOT_LAST    = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] DOT_M3      = DOT_W'(MODE2_DOTS);
  localparam logic [DOT_W-1:0] DOT_M3_MIN  = DOT_W'(MODE2_DOTS + MODE3_MIN - 1);
  localparam logic [DOT_W-1:0] DOT_M3_MAX  = DOT_W'(MODE2_DOTS + MODE3_MAX - 1);
  localparam logic [LY_W-1:0]  LY_LAST     = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]  LY_VBLANK   = LY_W'(VISIBLE_LINES);

  ppu_mode_t        mode_r, mode_nxt_s;
  logic [DOT_W-1:0] dot_r, dot_nxt_s;
  logic [LY_W-1:0]  ly_r, ly_nxt_s;
  logic             en_r;
  logic             done_seen_r, done_seen_nxt_s;
  logic             m2_start_r, m2_start_nxt_s;
  logic             m3_start_r, m3_start_nxt_s;
  logic             vblank_irq_r, vblank_irq_nxt_s;
  logic             frame_done_r, frame_done_nxt_s;
  logic             m3_overrun_r, m3_overrun_nxt_s;
  logic             lyc_eq_r;
  logic             stat_en_s;

  // Next-state for counters, mode FSM and event pulses
  always_comb begin
    dot_nxt_s        = dot_r;
    ly_nxt_s         = ly_r;
    mode_nxt_s       = mode_r;
    done_seen_nxt_s  = done_seen_r;
    m2_start_nxt_s   = 1'b0;
    m3_start_nxt_s   = 1'b0;
    vblank_irq_nxt_s = 1'b0;
    frame_done_nxt_s = 1'b0;
    m3_overrun_nxt_s = m3_overrun_r;

    if (!lcd_en) begin
      dot_nxt_s       = '0;
      ly_nxt_s        = '0;
      mode_nxt_s      = MODE_0;
      done_seen_nxt_s = 1'b0;
    end else if (!en_r) begin
      // First enabled cycle always starts a fresh frame in OAM search
      dot_nxt_s       = '0;
      ly_nxt_s        = '0;
      mode_nxt_s      = MODE_2;
      m2_start_nxt_s  = 1'b1;
      done_seen_nxt_s = 1'b0;
    end else begin
      if (dot_r == DOT_LAST) begin
        dot_nxt_s = '0;
        if (ly_r == LY_LAST) begin
          ly_nxt_s = '0;
        end else begin
          ly_nxt_s = ly_r + LY_W'(1);
        end
      end else begin
        dot_nxt_s = dot_r + DOT_W'(1);
        ly_nxt_s  = ly_r;
      end

      frame_done_nxt_s = (dot_nxt_s == DOT_LAST) && (ly_nxt_s == LY_LAST);

      if (dot_r == DOT_LAST) begin
        done_seen_nxt_s = 1'b0;
        if (ly_nxt_s < LY_VBLANK) begin
          mode_nxt_s     = MODE_2;
          m2_start_nxt_s = 1'b1;
        end else if (ly_nxt_s == LY_VBLANK) begin
          mode_nxt_s       = MODE_1;
          vblank_irq_nxt_s = 1'b1;
        end else begin
          mode_nxt_s = mode_r;
        end
      end else begin
        case (mode_r)
          MODE_2: begin
            if (dot_nxt_s == DOT_M3) begin
              mode_nxt_s      = MODE_3;
              m3_start_nxt_s  = 1'b1;
              done_seen_nxt_s = 1'b0;
            end else begin
              mode_nxt_s = mode_r;
            end
          end
          MODE_3: begin
            // Done at the timeout dot itself wins over the overrun branch
            if ((m3_done || done_seen_r) && (dot_r >= DOT_M3_MIN)) begin
              mode_nxt_s      = MODE_0;
              done_seen_nxt_s = 1'b0;
            end else if (dot_r >= DOT_M3_MAX) begin
              mode_nxt_s       = MODE_0;
              m3_overrun_nxt_s = 1'b1;
              done_seen_nxt_s  = 1'b0;
            end else begin
              done_seen_nxt_s = done_seen_r | m3_done;
            end
          end
          default: begin
            mode_nxt_s = mode_r;
          end
        endcase
      end
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r         <= 1'b0;
      dot_r        <= '0;
      ly_r         <= '0;
      mode_r       <= MODE_0;
      done_seen_r  <= 1'b0;
      m2_start_r   <= 1'b0;
      m3_start_r   <= 1'b0;
      vblank_irq_r <= 1'b0;
      frame_done_r <= 1'b0;
      m3_overrun_r <= 1'b0;
      lyc_eq_r     <= 1'b0;
    end else begin
      en_r         <= lcd_en;
      dot_r        <= dot_nxt_s;
      ly_r         <= ly_nxt_s;
      mode_r       <= mode_nxt_s;
      done_seen_r  <= done_seen_nxt_s;
      m2_start_r   <= m2_start_nxt_s;
      m3_start_r   <= m3_start_nxt_s;
      vblank_irq_r <= vblank_irq_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      m3_overrun_r <= m3_overrun_nxt_s;
      lyc_eq_r     <= (ly_r == lyc);
    end
  end

  // STAT requests only while the display is actually running
  assign stat_en_s = lcd_en & en_r;

  ppu_stat_irq u_stat_irq (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (stat_en_s),
    .stat_sel (stat_sel),
    .mode     (mode_r),
    .lyc_eq   (lyc_eq_r),
    .stat_irq (stat_irq)
  );

  assign mode       = mode_r;
  assign ly         = ly_r;
  assign dot        = dot_r;
  assign m2_start   = m2_start_r;
  assign m3_start   = m3_start_r;
  assign lyc_eq     = lyc_eq_r;
  assign vblank_irq = vblank_irq_r;
  assign frame_done = frame_done_r;
  assign m3_overrun = m3_overrun_r;

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// Directed bench for ppu_mode_sequencer at DMG timing: line modes, m3 timeout,
// LYC/STAT interrupts with blocking, display disable/enable and async reset.
module tb_ppu_mode_sequencer;

  localparam int DPL   = 456;
  localparam int FRAME = 456 * 154;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lcd_en = 1'b0;
  logic [3:0] stat_sel = 4'b0000;
  logic [7:0] lyc = 8'd10;
  logic       m3_done = 1'b0;
  logic [1:0] mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic       m2_start, m3_start, lyc_eq, stat_irq, vblank_irq, frame_done, m3_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ppu_mode_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_en     (lcd_en),
    .stat_sel   (stat_sel),
    .lyc        (lyc),
    .m3_done    (m3_done),
    .mode       (mode),
    .ly         (ly),
    .dot        (dot),
    .m2_start   (m2_start),
    .m3_start   (m3_start),
    .lyc_eq     (lyc_eq),
    .stat_irq   (stat_irq),
    .vblank_irq (vblank_irq),
    .frame_done (frame_done),
    .m3_overrun (m3_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mode, ly, dot, m2_start, m3_start, lyc_eq, stat_irq, vblank_irq, frame_done, m3_overrun} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: mode=%0d ly=%0d dot=%0d m3_overrun=%0b lyc_eq=%0b, required all zero",
               mode, ly, dot, m3_overrun, lyc_eq);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if ({mode, ly, dot, m2_start} !== 20'd0) begin
      miscompares++;
      $display("FAIL disabled_after_reset: mode=%0d ly=%0d dot=%0d m2_start=%0b, required 0", mode, ly, dot, m2_start);
    end
  endtask

  task automatic test_enable;
    lcd_en = 1'b1;
    tick();
    vectors++;
    if ({ly, dot, mode, m2_start} !== {8'd0, 9'd0, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL first_enabled_cycle: ly=%0d dot=%0d mode=%0d m2_start=%0b, required 0/0/2/1",
               ly, dot, mode, m2_start);
    end
  endtask

  // Line 0: m3_done pulsed while dot=299, so mode 0 starts at dot 300
  task automatic test_line_normal;
    logic [1:0] em;
    m3_done = 1'b0;
    for (int d = 1; d < DPL; d++) begin
      tick();
      em = (d < 80) ? 2'd2 : (d <= 299) ? 2'd3 : 2'd0;
      vectors++;
      if ({ly, dot, mode, m2_start, m3_start} !== {8'd0, 9'(d), em, 1'b0, (d == 80)}) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL normal_line d=%0d: ly=%0d dot=%0d mode=%0d m2s=%0b m3s=%0b, required mode %0d",
                   d, ly, dot, mode, m2_start, m3_start, em);
      end
      m3_done = (d == 299);
    end
  endtask

  // Line 1: early m3_done at dot 100 held off until the minimum (mode 0 at 252)
  task automatic test_line_early;
    logic [1:0] em;
    tick();
    vectors++;
    if ({ly, dot, mode, m2_start} !== {8'd1, 9'd0, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL line_wrap_456: ly=%0d dot=%0d mode=%0d m2_start=%0b, required 1/0/2/1", ly, dot, mode, m2_start);
    end
    for (int d = 1; d < DPL; d++) begin
      tick();
      em = (d < 80) ? 2'd2 : (d <= 251) ? 2'd3 : 2'd0;
      vectors++;
      if ({ly, dot, mode} !== {8'd1, 9'(d), em}) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL early_done d=%0d: ly=%0d dot=%0d mode=%0d, required mode %0d", d, ly, dot, mode, em);
      end
      m3_done = (d == 100);
    end
    vectors++;
    if (m3_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL early_done_overrun: m3_overrun=%0b, required 0", m3_overrun);
    end
  endtask

  // Line 2: m3_done exactly at the timeout dot 368 counts as done
  task automatic test_line_exact_timeout;
    logic [1:0] em;
    for (int d = 0; d < DPL; d++) begin
      tick();
      em = (d < 80) ? 2'd2 : (d <= 368) ? 2'd3 : 2'd0;
      vectors++;
      if ({ly, dot, mode} !== {8'd2, 9'(d), em}) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL exact_timeout d=%0d: ly=%0d dot=%0d mode=%0d, required mode %0d", d, ly, dot, mode, em);
      end
      m3_done = (d == 368);
    end
    vectors++;
    if (m3_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_timeout_overrun: m3_overrun=%0b, required 0", m3_overrun);
    end
  endtask

  // Line 3: no m3_done -> forced mode 0 after dot 368, overrun sticky
  task automatic test_line_overrun;
    logic [1:0] em;
    m3_done = 1'b0;
    for (int d = 0; d < DPL; d++) begin
      tick();
      em = (d < 80) ? 2'd2 : (d <= 368) ? 2'd3 : 2'd0;
      vectors++;
      if ({ly, dot, mode, m3_overrun} !== {8'd3, 9'(d), em, (d >= 369)}) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL overrun d=%0d: ly=%0d dot=%0d mode=%0d ovr=%0b, required mode %0d ovr %0b",
                   d, ly, dot, mode, m3_overrun, em, (d >= 369));
      end
    end
    tick();
    vectors++;
    if ({ly, dot, mode, m3_overrun} !== {8'd4, 9'd0, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_sticky: ly=%0d dot=%0d mode=%0d ovr=%0b, required 4/0/2/1", ly, dot, mode, m3_overrun);
    end
    m3_done = 1'b1;
  endtask

  task automatic test_lyc_irq;
    int budget = 0;
    int irq_cnt = 0;
    stat_sel = 4'b1000;
    while (ly !== 8'd10 && budget < 3500) begin
      tick();
      budget++;
      if (stat_irq === 1'b1) irq_cnt++;
    end
    vectors++;
    if (ly !== 8'd10) begin
      miscompares++;
      $display("FAIL lyc_wait_timeout: ly=%0d, required 10 within budget", ly);
    end
    vectors++;
    if ({dot, lyc_eq, irq_cnt[0]} !== {9'd0, 1'b0, 1'b0} || irq_cnt != 0) begin
      miscompares++;
      $display("FAIL lyc_before: dot=%0d lyc_eq=%0b irqs=%0d, required 0/0/0", dot, lyc_eq, irq_cnt);
    end
    tick();
    vectors++;
    if ({lyc_eq, stat_irq} !== 2'b10) begin
      miscompares++;
      $display("FAIL lyc_eq_rise: lyc_eq=%0b stat_irq=%0b, required 1/0", lyc_eq, stat_irq);
    end
    tick();
    vectors++;
    if (stat_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL lyc_stat_irq: stat_irq=%0b, required 1", stat_irq);
    end
    irq_cnt = 0;
    for (int i = 0; i < 909; i++) begin
      tick();
      if (stat_irq === 1'b1) irq_cnt++;
    end
    vectors++;
    if ({ly, dot} !== {8'd11, 9'd455} || irq_cnt != 0) begin
      miscompares++;
      $display("FAIL lyc_single_pulse: ly=%0d dot=%0d extra_irqs=%0d, required 11/455/0", ly, dot, irq_cnt);
    end
  endtask

  task automatic test_disable;
    int budget = 0;
    while (!(ly === 8'd12 && dot === 9'd300) && budget < 1000) begin
      tick();
      budget++;
    end
    vectors++;
    if ({ly, dot} !== {8'd12, 9'd300}) begin
      miscompares++;
      $display("FAIL disable_wait_timeout: ly=%0d dot=%0d, required 12/300", ly, dot);
    end
    lcd_en = 1'b0;
    stat_sel = 4'b0011;
    tick();
    vectors++;
    if ({ly, dot, mode, m3_overrun} !== {8'd0, 9'd0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL disable_abort: ly=%0d dot=%0d mode=%0d ovr=%0b, required 0/0/0/1", ly, dot, mode, m3_overrun);
    end
    for (int i = 1; i < 1000; i++) begin
      tick();
      vectors++;
      if ({mode, ly, dot, m2_start, m3_start, stat_irq, vblank_irq, frame_done} !== 24'd0) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL disabled_hold i=%0d: mode=%0d ly=%0d dot=%0d irq=%0b, required all 0", i, mode, ly, dot, stat_irq);
      end
    end
    lcd_en = 1'b1;
    tick();
    vectors++;
    if ({ly, dot, mode, m2_start, stat_irq} !== {8'd0, 9'd0, 2'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reenable: ly=%0d dot=%0d mode=%0d m2s=%0b irq=%0b, required 0/0/2/1/0",
               ly, dot, mode, m2_start, stat_irq);
    end
  endtask

  // Full frame with stat_sel=0011 and m3_done held: checks every cycle
  task automatic test_frame_vblank;
    int cc, el, ed;
    logic [1:0] em;
    logic [23:0] exp_v, obs_v;
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      cc = c % FRAME;
      el = cc / DPL;
      ed = cc % DPL;
      em = (el >= 144) ? 2'd1 : (ed < 80) ? 2'd2 : (ed <= 251) ? 2'd3 : 2'd0;
      exp_v = {em, 8'(el), 9'(ed), (el < 144 && ed == 0), (el < 144 && ed == 80),
               (el < 144 && ed == 253), (el == 144 && ed == 0), (el == 153 && ed == 455)};
      obs_v = {mode, ly, dot, m2_start, m3_start, stat_irq, vblank_irq, frame_done};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL frame c=%0d: got %h (ly=%0d dot=%0d mode=%0d), required %h", c, obs_v, ly, dot, mode, exp_v);
      end
    end
  endtask

  task automatic test_async_reset;
    lyc = 8'd0;
    for (int i = 0; i < 300; i++) tick();
    vectors++;
    if ({dot, lyc_eq, m3_overrun} !== {9'd300, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset: dot=%0d lyc_eq=%0b ovr=%0b, required 300/1/1", dot, lyc_eq, m3_overrun);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mode, ly, dot, m2_start, m3_start, lyc_eq, stat_irq, vblank_irq, frame_done, m3_overrun} !== 27'd0) begin
      miscompares++;
      $display("FAIL async_reset: mode=%0d ly=%0d dot=%0d lyc_eq=%0b ovr=%0b, required all zero",
               mode, ly, dot, lyc_eq, m3_overrun);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if ({ly, dot, mode, m2_start} !== {8'd0, 9'd0, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL after_reset_restart: ly=%0d dot=%0d mode=%0d m2s=%0b, required 0/0/2/1", ly, dot, mode, m2_start);
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_line_normal();
    test_line_early();
    test_line_exact_timeout();
    test_line_overrun();
    test_lyc_irq();
    test_disable();
    test_frame_vblank();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
